seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div_pkg.sv | 12 +
 rtl/cla_sub.sv | 38 +++
 rtl/seq_div.sv | 153 +++++++++++++++
 tb/tb_seq_div.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_sub.sv
// Parallel-prefix carry-lookahead subtractor: diff = a + ~b + 1.
// carry = 1 means a >= b (the difference is non-negative).
module cla_sub #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             carry
);

  // Generate/propagate prefix tree, then carries with a forced carry-in of 1.
  always_comb begin
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   c;
    p  = a ^ ~b;
    g  = a & ~b;
    gp = g;
    pp = p;
    // Descending index keeps gp[i-d]/pp[i-d] at their previous-stage values.
    for (int d = 1; d < int'(WIDTH); d = d * 2) begin
      for (int i = int'(WIDTH) - 1; i >= d; i--) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      c[i+1] = gp[i] | pp[i];
    end
    diff  = p ^ c[WIDTH-1:0];
    carry = c[WIDTH];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIV_DIV0_FAST_EN: a zero divisor finishes after one
// cycle instead of running the full iteration loop (same results).
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned TW = WIDTH + 1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] dsr_nx;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] quotient_nx;
  logic [WIDTH-1:0] remainder_nx;
  logic             div0_nx;
  logic             in_ready_nx;
  logic             out_valid_nx;

  logic [TW-1:0]    shifted_c;
  logic [TW-1:0]    trial_c;
  logic             nonneg_c;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign shifted_c = {rem_r, q_r[WIDTH-1]};

  // Trial subtraction of the latched divisor.
  cla_sub #(
    .WIDTH(TW)
  ) u_sub (
    .a     (shifted_c),
    .b     ({1'b0, dsr_r}),
    .diff  (trial_c),
    .carry (nonneg_c)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_nx     = state;
    rem_nx       = rem_r;
    q_nx         = q_r;
    dsr_nx       = dsr_r;
    cnt_nx       = cnt_r;
    quotient_nx  = quotient;
    remainder_nx = remainder;
    div0_nx      = div0;

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          dsr_nx   = divisor;
          rem_nx   = '0;
          q_nx     = dividend;
          cnt_nx   = '0;
          state_nx = CALC;
        end
      end

      CALC: begin
`ifdef SEQ_DIV_DIV0_FAST_EN
        // q_r still holds the untouched dividend on the first CALC cycle.
        if (dsr_r == '0) begin
          quotient_nx  = '1;
          remainder_nx = q_r;
          div0_nx      = 1'b1;
          cnt_nx       = '0;
          state_nx     = DONE;
        end else begin
`else
        begin
`endif
          if (nonneg_c) begin
            rem_nx = trial_c[WIDTH-1:0];
            q_nx   = {q_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_nx = shifted_c[WIDTH-1:0];
            q_nx   = {q_r[WIDTH-2:0], 1'b0};
          end
          cnt_nx = cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            quotient_nx  = q_nx;
            remainder_nx = rem_nx;
            div0_nx      = (dsr_r == '0);
            cnt_nx       = '0;
            state_nx     = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    in_ready_nx  = (state_nx == IDLE);
    out_valid_nx = (state_nx == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_r     <= '0;
      q_r       <= '0;
      dsr_r     <= '0;
      cnt_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      rem_r     <= rem_nx;
      q_r       <= q_nx;
      dsr_r     <= dsr_nx;
      cnt_r     <= cnt_nx;
      quotient  <= quotient_nx;
      remainder <= remainder_nx;
      div0      <= div0_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed and randomized self-checking bench for seq_div (WIDTH=8).
module tb_seq_div;

  localparam int unsigned W = 8;

`ifdef SEQ_DIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 8;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div0;

  int checks;
  int errors;

  seq_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // One full transaction; returns the result and edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pre_gap, input int post_gap,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (pre_gap) step();
    wait_ready();
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 0;
    while (!out_valid && lat < 64) begin
      step();
      lat++;
    end
    if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
    q = quotient;
    r = remainder;
    z = div0;
    repeat (post_gap) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         z;
  int           lat;
  int           cyc;
  logic         seen;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset values
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div0", 32'(div0), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 200/7
    run_op(8'd200, 8'd7, 0, 0, q, r, z, lat);
    check("200_7_q", 32'(q), 32'd28);
    check("200_7_r", 32'(r), 32'd4);
    check("200_7_div0", 32'(z), 32'd0);
    check("200_7_lat", 32'(lat), 32'd8);
    check("200_7_idle_ready", 32'(in_ready), 32'd1);
    check("200_7_idle_valid", 32'(out_valid), 32'd0);

    // 255/1 and 5/9
    run_op(8'd255, 8'd1, 1, 0, q, r, z, lat);
    check("255_1_q", 32'(q), 32'd255);
    check("255_1_r", 32'(r), 32'd0);
    run_op(8'd5, 8'd9, 0, 1, q, r, z, lat);
    check("5_9_q", 32'(q), 32'd0);
    check("5_9_r", 32'(r), 32'd5);
    run_op(8'd255, 8'd255, 0, 0, q, r, z, lat);
    check("255_255_q", 32'(q), 32'd1);
    check("255_255_r", 32'(r), 32'd0);
    run_op(8'd254, 8'd255, 0, 0, q, r, z, lat);
    check("254_255_r", 32'(r), 32'd254);
    run_op(8'd250, 8'd200, 0, 0, q, r, z, lat);
    check("250_200_q", 32'(q), 32'd1);
    check("250_200_r", 32'(r), 32'd50);

    // Zero divisor
    run_op(8'd77, 8'd0, 0, 0, q, r, z, lat);
    check("77_0_q", 32'(q), 32'd255);
    check("77_0_r", 32'(r), 32'd77);
    check("77_0_div0", 32'(z), 32'd1);
    check("77_0_lat", 32'(lat), 32'(DIV0_LAT));
    run_op(8'd9, 8'd3, 0, 0, q, r, z, lat);
    check("div0_clears", 32'(z), 32'd0);
    check("9_3_q", 32'(q), 32'd3);

    // Back-pressure: hold out_ready low for 5 cycles, with a new operand offered
    wait_ready();
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      step();
      lat++;
    end
    check("stall_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    dividend = 8'd10;
    divisor  = 8'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_hold_q", 32'(quotient), 32'd28);
      check("stall_hold_r", 32'(remainder), 32'd4);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready), 32'd1);
    check("stall_last_q", 32'(quotient), 32'd28);
    check("stall_last_r", 32'(remainder), 32'd4);

    // Back-to-back spacing with out_ready held high
    out_ready = 1'b1;
    dividend  = 8'd200;
    divisor   = 8'd7;
    in_valid  = 1'b1;
    wait_ready();
    step();
    cyc = 0;
    while (!in_ready && cyc < 64) begin
      step();
      cyc++;
    end
    check("spacing", 32'(cyc + 1), 32'(W + 2));
    step();
    in_valid = 1'b0;
    wait_ready();
    out_ready = 1'b0;

    // Reset in the middle of 100/3
    dividend = 8'd100;
    divisor  = 8'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_q", 32'(quotient), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("midrst_no_valid", 32'(seen), 32'd0);
    check("midrst_ready_after", 32'(in_ready), 32'd1);
    run_op(8'd100, 8'd3, 0, 0, q, r, z, lat);
    check("100_3_q", 32'(q), 32'd33);
    check("100_3_r", 32'(r), 32'd1);

    // Random operands with random stalls, checked by the division identity
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 19) == 0) ? W'(0) : W'($urandom_range(1, 255));
      run_op(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), q, r, z, lat);
      if (b == 0) begin
        check("rand_div0_q", 32'(q), 32'd255);
        check("rand_div0_r", 32'(r), 32'(a));
        check("rand_div0_flag", 32'(z), 32'd1);
      end else begin
        check("rand_identity", 32'(q) * 32'(b) + 32'(r), 32'(a));
        check("rand_rem_lt", 32'(r < b), 32'd1);
        check("rand_flag", 32'(z), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
